regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 80 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types and defaults for the writeback arbiter
package regfile_wb_arbiter_pkg;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    localparam int DEFAULT_ADDRESS_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH    = 32;

    // Bit positions of each requester in the req/grant vectors
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with one-hot grant
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    grant_e last_q;
    grant_e last_d;

    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // A tie favours whoever did not win the previous transfer
            2'b11:   grant = (last_q == GRANT_ALU) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        if (advance && (grant != 2'b00)) begin
            last_d = grant[REQ_MEM] ? GRANT_MEM : GRANT_ALU;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GRANT_ALU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates ALU and memory writebacks onto one register-file write port
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_wd,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     mem_ready,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]    WD3,
    output logic [15:0]              wr_count
);

    logic [1:0]               req;
    logic [1:0]               grant;
    logic                     xfer;
    logic [ADDRESS_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0]    sel_wd;

    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] ad_q, ad_d;
    logic [DATA_WIDTH-1:0]    wd_q, wd_d;
    logic [15:0]              cnt_q, cnt_d;

    // Requests are masked during reset so nothing can be accepted then
    assign req[REQ_ALU] = alu_valid & ~rst;
    assign req[REQ_MEM] = mem_valid & ~rst;

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (xfer),
        .grant   (grant)
    );

    assign xfer      = |grant;
    assign alu_ready = grant[REQ_ALU];
    assign mem_ready = grant[REQ_MEM];

    always_comb begin
        sel_rd = grant[REQ_MEM] ? mem_rd : alu_rd;
        sel_wd = grant[REQ_MEM] ? mem_wd : alu_wd;
        // Writes to x0 are accepted but dropped before the register file
        we_d   = xfer && (sel_rd != '0);
        ad_d   = we_d ? sel_rd : ad_q;
        wd_d   = we_d ? sel_wd : wd_q;
        cnt_d  = cnt_q + 16'(we_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q  <= 1'b0;
            ad_q  <= '0;
            wd_q  <= '0;
            cnt_q <= '0;
        end else begin
            we_q  <= we_d;
            ad_q  <= ad_d;
            wd_q  <= wd_d;
            cnt_q <= cnt_d;
        end
    end

    assign WE3      = we_q;
    assign AD3      = ad_q;
    assign WD3      = wd_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_wd;
    logic        mem_ready;
    logic        WE3;
    logic [4:0]  AD3;
    logic [31:0] WD3;
    logic [15:0] wr_count;

    int passed = 0;
    int total  = 0;

    regfile_wb_arbiter #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_wd    (alu_wd),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_wd    (mem_wd),
        .mem_ready (mem_ready),
        .WE3       (WE3),
        .AD3       (AD3),
        .WD3       (WD3),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int alu_n;
    int mem_n;
    logic exp_alu;

    initial begin
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_wd = 32'h1;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_wd = 32'h2;
        #2;
        check("rst_alu_ready", 64'(alu_ready), 64'(1'b0));
        check("rst_mem_ready", 64'(mem_ready), 64'(1'b0));
        tick();
        check("rst_we3", 64'(WE3), 64'(1'b0));
        check("rst_ad3", 64'(AD3), 64'(5'd0));
        check("rst_wd3", 64'(WD3), 64'(32'd0));
        check("rst_cnt", 64'(wr_count), 64'(16'd0));

        // Single ALU write
        rst = 1'b0;
        mem_valid = 1'b0;
        alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
        #1;
        check("t1_alu_ready", 64'(alu_ready), 64'(1'b1));
        check("t1_mem_ready", 64'(mem_ready), 64'(1'b0));
        tick();
        alu_valid = 1'b0;
        check("t1_we3", 64'(WE3), 64'(1'b1));
        check("t1_ad3", 64'(AD3), 64'(5'd5));
        check("t1_wd3", 64'(WD3), 64'(32'hDEADBEEF));
        check("t1_cnt", 64'(wr_count), 64'(16'd1));
        tick();
        check("t1_idle_we3", 64'(WE3), 64'(1'b0));
        check("t1_idle_ad3", 64'(AD3), 64'(5'd5));
        check("t1_idle_wd3", 64'(WD3), 64'(32'hDEADBEEF));
        check("t1_idle_cnt", 64'(wr_count), 64'(16'd1));

        // Tie from reset: mem first, then ALU
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_wd = 32'h22;
        #1;
        check("t2_mem_ready", 64'(mem_ready), 64'(1'b1));
        check("t2_alu_ready", 64'(alu_ready), 64'(1'b0));
        tick();
        mem_valid = 1'b0;
        check("t2_we3_a", 64'(WE3), 64'(1'b1));
        check("t2_ad3_a", 64'(AD3), 64'(5'd4));
        check("t2_wd3_a", 64'(WD3), 64'(32'h22));
        #1;
        check("t2_alu_ready_b", 64'(alu_ready), 64'(1'b1));
        tick();
        alu_valid = 1'b0;
        check("t2_we3_b", 64'(WE3), 64'(1'b1));
        check("t2_ad3_b", 64'(AD3), 64'(5'd3));
        check("t2_wd3_b", 64'(WD3), 64'(32'h11));
        check("t2_cnt", 64'(wr_count), 64'(16'd2));

        // Write to x0 is accepted but not issued
        mem_valid = 1'b1; mem_rd = 5'd0; mem_wd = 32'hFFFFFFFF;
        #1;
        check("t3_mem_ready", 64'(mem_ready), 64'(1'b1));
        tick();
        mem_valid = 1'b0;
        check("t3_we3", 64'(WE3), 64'(1'b0));
        check("t3_ad3_hold", 64'(AD3), 64'(5'd3));
        check("t3_cnt", 64'(wr_count), 64'(16'd2));

        // Continuous tie: last grant was mem, so ALU wins even cycles
        alu_n = 0; mem_n = 0;
        alu_valid = 1'b1; mem_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alu_rd = 5'(alu_n + 1);  alu_wd = 32'hA0000000 | 32'(alu_n);
            mem_rd = 5'(mem_n + 16); mem_wd = 32'hB0000000 | 32'(mem_n);
            exp_alu = (i % 2 == 0);
            #1;
            check($sformatf("t4_alu_ready_%0d", i), 64'(alu_ready), 64'(exp_alu));
            check($sformatf("t4_mem_ready_%0d", i), 64'(mem_ready), 64'(!exp_alu));
            tick();
            check($sformatf("t4_we3_%0d", i), 64'(WE3), 64'(1'b1));
            if (exp_alu) begin
                check($sformatf("t4_wd3_%0d", i), 64'(WD3), 64'(32'hA0000000 | 32'(alu_n)));
                alu_n++;
            end else begin
                check($sformatf("t4_wd3_%0d", i), 64'(WD3), 64'(32'hB0000000 | 32'(mem_n)));
                mem_n++;
            end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("t4_cnt", 64'(wr_count), 64'(16'd10));

        // Same rd from both: ALU first (mem won last), mem's data lands last
        alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'hAA;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_wd = 32'hBB;
        tick();
        alu_valid = 1'b0;
        check("t5_wd3_first", 64'(WD3), 64'(32'hAA));
        tick();
        mem_valid = 1'b0;
        check("t5_ad3", 64'(AD3), 64'(5'd7));
        check("t5_wd3_last", 64'(WD3), 64'(32'hBB));
        check("t5_cnt", 64'(wr_count), 64'(16'd12));

        // Reset right after a transfer kills the pending write
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'h99;
        tick();
        alu_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_we3_in_rst", 64'(WE3), 64'(1'b0));
        check("t6_cnt_in_rst", 64'(wr_count), 64'(16'd0));
        tick();
        rst = 1'b0;
        check("t6_we3_edge", 64'(WE3), 64'(1'b0));
        tick();
        check("t6_we3_after", 64'(WE3), 64'(1'b0));
        check("t6_cnt_after", 64'(wr_count), 64'(16'd0));

        // Counter wrap
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'h5;
        repeat (65535) begin
            @(posedge clk);
        end
        #1;
        check("t7_cnt_ffff", 64'(wr_count), 64'(16'hFFFF));
        tick();
        alu_valid = 1'b0;
        check("t7_cnt_wrap", 64'(wr_count), 64'(16'h0000));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
